// File: rtl/uart_pkg.sv
// Shared UART definitions: frame line levels, data width and the receiver state type.
// Used by both the transmitter and the receiver so their framing cannot drift apart.
package uart_pkg;

    localparam int DATA_BITS          = 8;
    localparam int OVERSAMPLE_DEFAULT = 16;

    // Line levels of an 8N1 frame; the stop level doubles as the idle level.
    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        RX_START   = 3'd1,
        RX_DATA    = 3'd2,
        RX_STOP    = 3'd3,
        RX_WAIT_HI = 3'd4
    } rx_state_t;

endpackage

// File: rtl/rx_bit_timer.sv
// Oversample counter and bit index for the UART receiver; raises strobes at the
// half-bit and full-bit points of the current bit period.
module rx_bit_timer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int CLEAR_VAL  = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    input  logic bit_step,
    output logic half_strobe,
    output logic full_strobe,
    output logic last_bit
);

    localparam int SAMP_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [SAMP_W-1:0] HALF_PT = SAMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMP_W-1:0] FULL_PT = SAMP_W'(OVERSAMPLE - 1);
    localparam logic [SAMP_W-1:0] CLR_PT  = SAMP_W'(CLEAR_VAL);
    localparam logic [BIT_W-1:0]  LAST_PT = BIT_W'(DATA_BITS - 1);

    logic [SAMP_W-1:0] samp_cnt_reg;
    logic [BIT_W-1:0]  bit_idx_reg;

    // The counter wraps naturally, so each full-bit strobe is exactly OVERSAMPLE apart.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            samp_cnt_reg <= '0;
            bit_idx_reg  <= '0;
        end else begin
            if (clear) begin
                samp_cnt_reg <= CLR_PT;
            end else if (run) begin
                samp_cnt_reg <= samp_cnt_reg + SAMP_W'(1);
            end else begin
                samp_cnt_reg <= '0;
            end

            if (clear) begin
                bit_idx_reg <= '0;
            end else if (bit_step) begin
                bit_idx_reg <= bit_idx_reg + BIT_W'(1);
            end
        end
    end

    assign half_strobe = (samp_cnt_reg == HALF_PT);
    assign full_strobe = (samp_cnt_reg == FULL_PT);
    assign last_bit    = (bit_idx_reg == LAST_PT);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with mid-bit sampling and a one-byte ready/valid output buffer.
// Define UART_RX_MAJORITY_VOTE_EN to take a 2-of-3 vote around every sample point.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_serial_in,
    input  logic       rx_data_ready,
    output logic       rx_data_valid,
    output logic [7:0] rx_data,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam logic [2:0] ST_IDLE    = RX_IDLE;
    localparam logic [2:0] ST_START   = RX_START;
    localparam logic [2:0] ST_DATA    = RX_DATA;
    localparam logic [2:0] ST_STOP    = RX_STOP;
    localparam logic [2:0] ST_WAIT_HI = RX_WAIT_HI;

`ifdef UART_RX_MAJORITY_VOTE_EN
    // The vote decides one cycle after the point, so the data phase starts one count ahead.
    localparam int TIMER_CLEAR = 1;
`else
    localparam int TIMER_CLEAR = 0;
`endif

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_s;

    logic [2:0]           state_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic [7:0]           data_reg;
    logic                 valid_reg;
    logic                 ferr_reg;
    logic                 ovr_reg;

    logic half_strobe;
    logic full_strobe;
    logic last_bit;
    logic half_evt;
    logic full_evt;
    logic samp_bit;
    logic timer_run;
    logic timer_clear;
    logic bit_step;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg <= {SYNC_STAGES{LINE_IDLE}};
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx_serial_in};
        end
    end

    assign rx_s = sync_reg[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic rx_hist1_reg;
    logic rx_hist2_reg;
    logic half_q_reg;
    logic full_q_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_hist1_reg <= LINE_IDLE;
            rx_hist2_reg <= LINE_IDLE;
            half_q_reg   <= 1'b0;
            full_q_reg   <= 1'b0;
        end else begin
            rx_hist1_reg <= rx_s;
            rx_hist2_reg <= rx_hist1_reg;
            half_q_reg   <= half_strobe;
            full_q_reg   <= full_strobe;
        end
    end

    // Window is rx_s at point-1, point and point+1; this cycle is point+1.
    assign half_evt = half_q_reg;
    assign full_evt = full_q_reg;
    assign samp_bit = (rx_hist2_reg & rx_hist1_reg) | (rx_hist2_reg & rx_s) | (rx_hist1_reg & rx_s);
`else
    assign half_evt = half_strobe;
    assign full_evt = full_strobe;
    assign samp_bit = rx_s;
`endif

    assign timer_run   = (state_reg == ST_START) || (state_reg == ST_DATA) || (state_reg == ST_STOP);
    assign timer_clear = (state_reg == ST_START) && half_evt && (samp_bit == START_LEVEL);
    assign bit_step    = (state_reg == ST_DATA) && full_evt;

    rx_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE),
        .CLEAR_VAL  (TIMER_CLEAR)
    ) u_bit_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (timer_clear),
        .run         (timer_run),
        .bit_step    (bit_step),
        .half_strobe (half_strobe),
        .full_strobe (full_strobe),
        .last_bit    (last_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            shift_reg <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
            ovr_reg   <= 1'b0;
        end else begin
            ferr_reg <= 1'b0;
            ovr_reg  <= 1'b0;

            if (valid_reg && rx_data_ready) begin
                valid_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (rx_s == START_LEVEL) begin
                        state_reg <= ST_START;
                    end
                end
                ST_START: begin
                    // A start bit that is gone by mid-bit was a glitch: drop it silently.
                    if (half_evt) begin
                        state_reg <= (samp_bit == START_LEVEL) ? ST_DATA : ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (full_evt) begin
                        shift_reg <= {samp_bit, shift_reg[DATA_BITS-1:1]};
                        if (last_bit) begin
                            state_reg <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (full_evt) begin
                        if (samp_bit == STOP_LEVEL) begin
                            state_reg <= ST_IDLE;
                            // A byte leaving this same cycle frees the buffer for the new one.
                            if (!valid_reg || rx_data_ready) begin
                                data_reg  <= shift_reg;
                                valid_reg <= 1'b1;
                            end else begin
                                ovr_reg <= 1'b1;
                            end
                        end else begin
                            ferr_reg  <= 1'b1;
                            state_reg <= ST_WAIT_HI;
                        end
                    end
                end
                ST_WAIT_HI: begin
                    // Hold here so a break line reports a single framing error.
                    if (rx_s == LINE_IDLE) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_data_valid = valid_reg;
    assign rx_data       = data_reg;
    assign rx_frame_err  = ferr_reg;
    assign rx_overrun    = ovr_reg;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: builds whole-phase line waveforms, predicts outputs from frame
// timing arithmetic, and compares the DUT every cycle.
module tb_uart_receiver;

    localparam int OS   = 16;
    localparam int SS   = 2;
    localparam int MAXN = 6000;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int LAT = 1;
    localparam bit MAJ = 1'b1;
`else
    localparam int LAT = 0;
    localparam bit MAJ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_serial_in = 1'b1;
    logic       rx_data_ready = 1'b0;
    logic       rx_data_valid;
    logic [7:0] rx_data;
    logic       rx_frame_err;
    logic       rx_overrun;

    uart_receiver #(
        .OVERSAMPLE  (OS),
        .SYNC_STAGES (SS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_serial_in  (rx_serial_in),
        .rx_data_ready (rx_data_ready),
        .rx_data_valid (rx_data_valid),
        .rx_data       (rx_data),
        .rx_frame_err  (rx_frame_err),
        .rx_overrun    (rx_overrun)
    );

    always #5 clk = ~clk;

    // Stimulus per cycle: values applied before clock edge c.
    bit         line_a [MAXN];
    bit         rst_a  [MAXN];
    bit         rdy_a  [MAXN+1];
    int         n_cyc;
    // Model: frame events and expected outputs right after edge c.
    bit         ev_good [MAXN];
    logic [7:0] ev_byte [MAXN];
    bit         ev_ferr [MAXN];
    bit         exp_valid [MAXN];
    logic [7:0] exp_data  [MAXN];
    bit         exp_ferr  [MAXN];
    bit         exp_ovr   [MAXN];

    int vectors = 0;
    int miscompares = 0;
    int cur_cyc = 0;
    int phase_id = 0;
    bit checking = 1'b0;
    int ferr_cnt, ovr_cnt, valid_cycles;
    logic [7:0] xfer_q [$];

    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic new_phase(input int id);
        phase_id = id;
        n_cyc = 0;
        for (int i = 0; i < MAXN; i++) begin
            line_a[i] = 1'b1;
            rst_a[i]  = 1'b0;
            rdy_a[i]  = 1'b0;
        end
        rdy_a[MAXN] = 1'b0;
    endtask

    task automatic put(input bit v, input bit r, input int n);
        for (int i = 0; i < n; i++) begin
            if (n_cyc < MAXN) begin
                line_a[n_cyc] = v;
                rst_a[n_cyc]  = r;
                n_cyc++;
            end
        end
    endtask

    // Serialised 8N1 frame; optional single-cycle glitch at the middle of every data bit.
    task automatic add_frame(input logic [7:0] b, input bit stop_ok, input bit glitch);
        bit v;
        put(1'b0, 1'b0, OS);
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < OS; j++) begin
                v = b[k];
                if (glitch && j == OS / 2) v = !v;
                put(v, 1'b0, 1);
            end
        end
        put(stop_ok, 1'b0, OS);
    endtask

    task automatic fill_ready(input int mode, input int from);
        for (int i = from; i <= MAXN; i++) begin
            if (mode == 2) rdy_a[i] = ($urandom_range(0, 3) != 0);
            else           rdy_a[i] = (mode == 1);
        end
    endtask

    // Synchronised line seen after edge c: line delayed SS-1 edges, forced high by reset.
    function automatic bit rxs_at(input int c);
        if (c < SS - 1) return 1'b1;
        for (int k = 0; k < SS; k++) begin
            if (c - k >= 0 && c - k < MAXN && rst_a[c-k]) return 1'b1;
        end
        if (c - SS + 1 >= n_cyc) return 1'b1;
        return line_a[c-SS+1];
    endfunction

    function automatic bit samp(input int p);
        int s;
        if (!MAJ) return rxs_at(p);
        s = int'(rxs_at(p - 1)) + int'(rxs_at(p)) + int'(rxs_at(p + 1));
        return (s >= 2);
    endfunction

    function automatic int first_rst(input int a, input int b);
        for (int i = a; i <= b && i < n_cyc; i++) begin
            if (rst_a[i]) return i;
        end
        return -1;
    endfunction

    task automatic build_model();
        int c, r, d, w;
        logic [7:0] b;
        bit v;
        logic [7:0] dat;
        for (int i = 0; i < MAXN; i++) begin
            ev_good[i] = 1'b0;
            ev_byte[i] = 8'h00;
            ev_ferr[i] = 1'b0;
        end
        // c: a cycle after which the receiver is idle and watches the line.
        c = 0;
        while (c < n_cyc) begin
            if (rst_a[c] || rxs_at(c)) begin
                c++;
                continue;
            end
            r = first_rst(c + 1, c + 9 + LAT);
            if (r >= 0) begin c = r; continue; end
            if (c + 9 + LAT >= n_cyc) break;
            if (samp(c + OS / 2)) begin
                c = c + 9 + LAT;
                continue;
            end
            d = c + 153 + LAT;
            r = first_rst(c + 1, d);
            if (r >= 0) begin c = r; continue; end
            if (d >= n_cyc) break;
            for (int k = 0; k < 8; k++) b[k] = samp(c + 24 + OS * k);
            if (samp(c + 152)) begin
                ev_good[d] = 1'b1;
                ev_byte[d] = b;
                c = d;
            end else begin
                ev_ferr[d] = 1'b1;
                w = d;
                while (w < n_cyc && !rst_a[w] && !rxs_at(w)) w++;
                c = (w < n_cyc && rst_a[w]) ? w : w + 1;
            end
        end
        // One-byte buffer driven by the delivery events and the ready pattern.
        v = 1'b0;
        dat = 8'h00;
        for (int i = 0; i < n_cyc; i++) begin
            exp_ferr[i] = 1'b0;
            exp_ovr[i]  = 1'b0;
            if (rst_a[i]) begin
                v = 1'b0;
                dat = 8'h00;
            end else begin
                exp_ferr[i] = ev_ferr[i];
                if (ev_good[i]) begin
                    if (!v || rdy_a[i]) begin
                        v = 1'b1;
                        dat = ev_byte[i];
                    end else begin
                        exp_ovr[i] = 1'b1;
                    end
                end else if (v && rdy_a[i]) begin
                    v = 1'b0;
                end
            end
            exp_valid[i] = v;
            exp_data[i]  = dat;
        end
    endtask

    task automatic run_phase();
        build_model();
        ferr_cnt = 0;
        ovr_cnt = 0;
        valid_cycles = 0;
        xfer_q.delete();
        for (int c = 0; c < n_cyc; c++) begin
            @(negedge clk);
            cur_cyc       = c;
            rst_n         = !rst_a[c];
            rx_serial_in  = line_a[c];
            rx_data_ready = rdy_a[c];
            checking      = 1'b1;
        end
        @(negedge clk);
        checking = 1'b0;
    endtask

    // Per-cycle comparison against the model, plus observation counters for literal checks.
    always begin : compare
        int c;
        @(posedge clk);
        #1;
        if (checking) begin
            c = cur_cyc;
            vectors++;
            if ({rx_data_valid, rx_data, rx_frame_err, rx_overrun} !==
                {exp_valid[c], exp_data[c], exp_ferr[c], exp_ovr[c]}) begin
                miscompares++;
                if (miscompares <= 40)
                    $display("FAIL outputs phase %0d cycle %0d: got v=%0b d=%02h fe=%0b ov=%0b, expected v=%0b d=%02h fe=%0b ov=%0b",
                             phase_id, c, rx_data_valid, rx_data, rx_frame_err, rx_overrun,
                             exp_valid[c], exp_data[c], exp_ferr[c], exp_ovr[c]);
            end
            if (!rst_a[c]) begin
                if (rx_data_valid) valid_cycles++;
                if (rx_frame_err) ferr_cnt++;
                if (rx_overrun) ovr_cnt++;
                if (rx_data_valid && rdy_a[c+1] && c + 1 < n_cyc && !rst_a[c+1]) xfer_q.push_back(rx_data);
            end
        end
    end

    function automatic int model_first_good();
        for (int i = 0; i < n_cyc; i++) if (ev_good[i]) return i;
        return -1;
    endfunction

    function automatic int model_count(input int kind);
        int n = 0;
        for (int i = 0; i < n_cyc; i++) begin
            if (kind == 0 && ev_good[i]) n++;
            if (kind == 1 && ev_ferr[i]) n++;
            if (kind == 2 && exp_ovr[i]) n++;
        end
        return n;
    endfunction

    initial begin
        int f, g, on_cyc;
        logic [7:0] pat [3];
        pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h55;

        // Phase 1: single 0xA5 frame, ready held high.
        new_phase(1);
        put(1'b1, 1'b1, 4); put(1'b1, 1'b0, 16);
        add_frame(8'hA5, 1'b1, 1'b0);
        put(1'b1, 1'b0, 40);
        fill_ready(1, 0);
        build_model();
        g = model_first_good();
        chk("p1_model_cycle", g, 174 + LAT);
        chk("p1_model_byte", (g >= 0) ? int'(ev_byte[g]) : -1, 8'hA5);
        run_phase();
        chk("p1_valid_cycles", valid_cycles, 1);
        chk("p1_xfer_count", xfer_q.size(), 1);
        if (xfer_q.size() > 0) chk("p1_xfer_byte", xfer_q[0], 8'hA5);
        chk("p1_frame_err", ferr_cnt, 0);

        // Phase 2: 4-cycle low glitch is rejected.
        new_phase(2);
        put(1'b1, 1'b1, 4); put(1'b1, 1'b0, 10); put(1'b0, 1'b0, 4); put(1'b1, 1'b0, 40);
        fill_ready(1, 0);
        run_phase();
        chk("p2_model_events", model_count(0) + model_count(1), 0);
        chk("p2_valid_cycles", valid_cycles, 0);
        chk("p2_frame_err", ferr_cnt, 0);

        // Phase 3: bad stop bit, then a good frame.
        new_phase(3);
        put(1'b1, 1'b1, 4); put(1'b1, 1'b0, 16);
        add_frame(8'h3C, 1'b0, 1'b0);
        put(1'b1, 1'b0, 24);
        add_frame(8'h11, 1'b1, 1'b0);
        put(1'b1, 1'b0, 40);
        fill_ready(1, 0);
        run_phase();
        chk("p3_model_ferr", model_count(1), 1);
        chk("p3_frame_err", ferr_cnt, 1);
        chk("p3_xfer_count", xfer_q.size(), 1);
        if (xfer_q.size() > 0) chk("p3_xfer_byte", xfer_q[0], 8'h11);

        // Phase 4: two back-to-back frames while the host is stalled.
        new_phase(4);
        put(1'b1, 1'b1, 4); put(1'b1, 1'b0, 16);
        add_frame(8'h12, 1'b1, 1'b0);
        add_frame(8'h34, 1'b1, 1'b0);
        put(1'b1, 1'b0, 20);
        on_cyc = n_cyc;
        put(1'b1, 1'b0, 40);
        fill_ready(0, 0);
        fill_ready(1, on_cyc);
        run_phase();
        chk("p4_model_overrun", model_count(2), 1);
        chk("p4_overrun", ovr_cnt, 1);
        chk("p4_xfer_count", xfer_q.size(), 1);
        if (xfer_q.size() > 0) chk("p4_xfer_byte", xfer_q[0], 8'h12);
        chk("p4_final_data", rx_data, 8'h12);
        chk("p4_final_valid", rx_data_valid, 0);

        // Phase 5: reset during bit 4 of 0xFF, then 0x81.
        new_phase(5);
        put(1'b1, 1'b1, 4); put(1'b1, 1'b0, 16);
        f = n_cyc;
        add_frame(8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) rst_a[f + OS * 5 + 4 + i] = 1'b1;
        put(1'b1, 1'b0, 30);
        add_frame(8'h81, 1'b1, 1'b0);
        put(1'b1, 1'b0, 40);
        fill_ready(1, 0);
        run_phase();
        chk("p5_xfer_count", xfer_q.size(), 1);
        if (xfer_q.size() > 0) chk("p5_xfer_byte", xfer_q[0], 8'h81);
        chk("p5_frame_err", ferr_cnt, 0);

        // Phase 6: continuous stream 00/FF/55, mid-bit glitches when voting is built in.
        new_phase(6);
        put(1'b1, 1'b1, 4); put(1'b1, 1'b0, 16);
        for (int i = 0; i < 12; i++) add_frame(pat[i % 3], 1'b1, MAJ);
        put(1'b1, 1'b0, 40);
        fill_ready(1, 0);
        run_phase();
        chk("p6_xfer_count", xfer_q.size(), 12);
        for (int i = 0; i < xfer_q.size() && i < 12; i++) chk("p6_xfer_byte", xfer_q[i], pat[i % 3]);
        chk("p6_errors", ferr_cnt + ovr_cnt, 0);

        // Phase 7: random bytes, stop errors, idle glitches, gaps and ready pattern.
        new_phase(7);
        put(1'b1, 1'b1, 4); put(1'b1, 1'b0, 16);
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                put(1'b0, 1'b0, $urandom_range(1, 6));
                put(1'b1, 1'b0, 16);
            end
            add_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0),
                      MAJ && ($urandom_range(0, 1) != 0));
            put(1'b1, 1'b0, $urandom_range(0, 24));
        end
        put(1'b1, 1'b0, 40);
        fill_ready(2, 0);
        run_phase();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
